// File: rtl/lbu_ptr_sequencer.sv
// Loop-buffer pointer sequencer: walks a signed [start,end] range by a signed
// stride, emitting cfg_count pointers over a valid/ready stream, with optional wrap.
module lbu_ptr_sequencer #(
  parameter int P_PTR    = 24,
  parameter int P_STRIDE = 8,
  parameter int P_CNT    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic signed [P_PTR-1:0]   cfg_start,
  input  logic signed [P_PTR-1:0]   cfg_end,
  input  logic signed [P_STRIDE-1:0] cfg_stride,
  input  logic                      cfg_decr,
  input  logic                      cfg_wa_en,
  input  logic [P_CNT-1:0]          cfg_count,
  input  logic                      abort,
  output logic                      ptr_valid,
  input  logic                      ptr_ready,
  output logic signed [P_PTR-1:0]   ptr_out,
  output logic                      ptr_last,
  output logic                      done,
  output logic                      busy
);

  localparam int W = P_PTR + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e                 state_q, state_d;
  logic signed [P_PTR-1:0] ptr_q, ptr_d;
  logic signed [P_PTR-1:0] start_q, start_d;
  logic signed [P_PTR-1:0] end_q, end_d;
  logic signed [W-1:0]     step_q, step_d;
  logic                    wa_q, wa_d;
  logic [P_CNT-1:0]        rem_q, rem_d;

  logic signed [W-1:0] stride_ext, cfg_eff;
  logic signed [W-1:0] next, start_ext, end_ext;
  logic                step_neg, over, last;

  // One extra bit keeps negation of the most negative stride and ptr+step exact.
  assign stride_ext = {{(W-P_STRIDE){cfg_stride[P_STRIDE-1]}}, cfg_stride};
  assign cfg_eff    = cfg_decr ? -stride_ext : stride_ext;

  assign next      = {ptr_q[P_PTR-1], ptr_q} + step_q;
  assign start_ext = {start_q[P_PTR-1], start_q};
  assign end_ext   = {end_q[P_PTR-1], end_q};
  assign step_neg  = step_q[W-1];
  assign over      = step_neg ? (next < start_ext) : (next > end_ext);
  assign last      = (state_q == S_RUN) && ((rem_q == P_CNT'(1)) || (!wa_q && over));

  assign cfg_ready = (state_q == S_IDLE);
  assign busy      = (state_q == S_RUN);
  assign ptr_valid = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign ptr_out   = ptr_q;
  assign ptr_last  = last;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    start_d = start_q;
    end_d   = end_q;
    step_d  = step_q;
    wa_d    = wa_q;
    rem_d   = rem_q;
    case (state_q)
      S_IDLE: begin
        if (cfg_valid) begin
          start_d = cfg_start;
          end_d   = cfg_end;
          step_d  = cfg_eff;
          wa_d    = cfg_wa_en;
          rem_d   = cfg_count;
          ptr_d   = cfg_eff[W-1] ? cfg_end : cfg_start;
          state_d = (cfg_count != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        // Abort wins over a same-cycle handshake; the update is dropped.
        if (abort) begin
          state_d = S_IDLE;
        end else if (ptr_ready) begin
          rem_d = rem_q - P_CNT'(1);
          if (last)      state_d = S_DONE;
          else if (over) ptr_d   = step_neg ? end_q : start_q;
          else           ptr_d   = next[P_PTR-1:0];
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      start_q <= '0;
      end_q   <= '0;
      step_q  <= '0;
      wa_q    <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      start_q <= start_d;
      end_q   <= end_d;
      step_q  <= step_d;
      wa_q    <= wa_d;
      rem_q   <= rem_d;
    end
  end

endmodule

// File: tb/tb_lbu_ptr_sequencer.sv
// Directed bench for lbu_ptr_sequencer: table of walks plus abort/reset/count=0 sequences.
module tb_lbu_ptr_sequencer;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               cfg_valid = 1'b0;
  logic               cfg_ready;
  logic signed [23:0] cfg_start = '0;
  logic signed [23:0] cfg_end = '0;
  logic signed [7:0]  cfg_stride = '0;
  logic               cfg_decr = 1'b0;
  logic               cfg_wa_en = 1'b0;
  logic [15:0]        cfg_count = '0;
  logic               abort = 1'b0;
  logic               ptr_valid;
  logic               ptr_ready = 1'b0;
  logic signed [23:0] ptr_out;
  logic               ptr_last;
  logic               done;
  logic               busy;

  int n_chk = 0;
  int n_fail = 0;

  lbu_ptr_sequencer #(.P_PTR(24), .P_STRIDE(8), .P_CNT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_start(cfg_start), .cfg_end(cfg_end), .cfg_stride(cfg_stride),
    .cfg_decr(cfg_decr), .cfg_wa_en(cfg_wa_en), .cfg_count(cfg_count),
    .abort(abort),
    .ptr_valid(ptr_valid), .ptr_ready(ptr_ready), .ptr_out(ptr_out),
    .ptr_last(ptr_last), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0]       start;
    logic [23:0]       endp;
    logic [7:0]        stride;
    logic              decr;
    logic              wa;
    logic [15:0]       count;
    logic [3:0]        n;
    logic [4:0][23:0]  ex;
  } vec_t;

  vec_t vt [9];

  function automatic vec_t mk(int s, int e, int st, bit d, bit w, int c, int n,
                              int e0, int e1, int e2, int e3, int e4);
    vec_t v;
    v.start  = 24'(s);
    v.endp   = 24'(e);
    v.stride = 8'(st);
    v.decr   = d;
    v.wa     = w;
    v.count  = 16'(c);
    v.n      = 4'(n);
    v.ex[0]  = 24'(e0);
    v.ex[1]  = 24'(e1);
    v.ex[2]  = 24'(e2);
    v.ex[3]  = 24'(e3);
    v.ex[4]  = 24'(e4);
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic accept(input vec_t v);
    @(negedge clk);
    chk("cfg_ready_before_accept", int'(cfg_ready), 1);
    cfg_start  = v.start;
    cfg_end    = v.endp;
    cfg_stride = v.stride;
    cfg_decr   = v.decr;
    cfg_wa_en  = v.wa;
    cfg_count  = v.count;
    cfg_valid  = 1'b1;
    @(negedge clk);
    cfg_valid  = 1'b0;
  endtask

  // Drains one walk; with bp set, ptr_ready alternates 0/1 starting with a stall,
  // and the stalled pointer must still equal the expected value next cycle.
  task automatic run_walk(input vec_t v, input bit bp, input string tag);
    int idx = 0;
    int cyc = 0;
    accept(v);
    while (idx < int'(v.n) && cyc < 64) begin
      chk({tag, "_valid"}, int'(ptr_valid), 1);
      chk({tag, "_busy"}, int'(busy), 1);
      chk({tag, "_ptr"}, int'(ptr_out), int'($signed(v.ex[idx])));
      chk({tag, "_last"}, int'(ptr_last), (idx == int'(v.n) - 1) ? 1 : 0);
      ptr_ready = bp ? cyc[0] : 1'b1;
      @(negedge clk);
      if (ptr_ready && ptr_valid === 1'b0) idx = idx;
      if (ptr_ready) idx++;
      cyc++;
    end
    ptr_ready = 1'b0;
    chk({tag, "_completed"}, idx, int'(v.n));
    chk({tag, "_done"}, int'(done), 1);
    chk({tag, "_valid_off"}, int'(ptr_valid), 0);
    @(negedge clk);
    chk({tag, "_done_1cyc"}, int'(done), 0);
    chk({tag, "_idle"}, int'(cfg_ready), 1);
  endtask

  initial begin
    vt[0] = mk(0, 20, 8, 0, 0, 10, 3, 0, 8, 16, 0, 0);
    vt[1] = mk(0, 20, 8, 0, 1, 5, 5, 0, 8, 16, 0, 8);
    vt[2] = mk(-4, 4, 3, 1, 1, 5, 5, 4, 1, -2, 4, 1);
    vt[3] = mk(5, 9, 0, 0, 0, 3, 3, 5, 5, 5, 0, 0);
    vt[4] = mk(10, 2, 1, 0, 0, 4, 1, 10, 0, 0, 0, 0);
    vt[5] = mk(10, 2, 1, 0, 1, 3, 3, 10, 10, 10, 0, 0);
    vt[6] = mk(-4, 4, 3, 1, 0, 9, 3, 4, 1, -2, 0, 0);
    vt[7] = mk(0, 5, -2, 0, 0, 10, 3, 5, 3, 1, 0, 0);
    vt[8] = mk(7, 100, 8, 0, 0, 1, 1, 7, 0, 0, 0, 0);

    // Reset values
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_cfg_ready", int'(cfg_ready), 1);
    chk("rst_ptr_valid", int'(ptr_valid), 0);
    chk("rst_ptr_last", int'(ptr_last), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ptr_out", int'(ptr_out), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_walk(vt[i], 1'b0, $sformatf("vec%0d", i));

    // Backpressure on the no-wrap and wrap walks
    run_walk(vt[0], 1'b1, "bp0");
    run_walk(vt[1], 1'b1, "bp1");

    // count == 0: no pointer, done one cycle after accept
    begin
      vec_t z;
      z = vt[0];
      z.count = '0;
      accept(z);
      chk("cnt0_valid", int'(ptr_valid), 0);
      chk("cnt0_done", int'(done), 1);
      @(negedge clk);
      chk("cnt0_done_off", int'(done), 0);
      chk("cnt0_idle", int'(cfg_ready), 1);
    end

    // Abort after the second pointer of the wrap walk, with a same-cycle handshake
    accept(vt[1]);
    ptr_ready = 1'b1;
    chk("abt_p0", int'(ptr_out), 0);
    @(negedge clk);
    chk("abt_p1", int'(ptr_out), 8);
    @(negedge clk);
    chk("abt_p2", int'(ptr_out), 16);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    ptr_ready = 1'b0;
    chk("abt_idle", int'(cfg_ready), 1);
    chk("abt_valid", int'(ptr_valid), 0);
    chk("abt_done", int'(done), 0);
    @(negedge clk);
    chk("abt_done_later", int'(done), 0);

    // Abort held high in IDLE must not block an accept
    abort = 1'b1;
    accept(vt[8]);
    abort = 1'b0;
    chk("abt_idle_valid", int'(ptr_valid), 1);
    chk("abt_idle_ptr", int'(ptr_out), 7);
    chk("abt_idle_last", int'(ptr_last), 1);
    ptr_ready = 1'b1;
    @(negedge clk);
    ptr_ready = 1'b0;
    chk("abt_idle_done", int'(done), 1);
    @(negedge clk);

    // Reset mid-walk: outputs drop at once, no done, accept right after release
    accept(vt[1]);
    ptr_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("mid_ptr_before_rst", int'(ptr_out), 16);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", int'(ptr_valid), 0);
    chk("mid_rst_ready", int'(cfg_ready), 1);
    chk("mid_rst_last", int'(ptr_last), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_ptr", int'(ptr_out), 0);
    ptr_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rel_done", int'(done), 0);
    run_walk(vt[2], 1'b0, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: got running expected finished");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1);
  end

endmodule
